// File: rtl/exc_tracker_pkg.sv
// Shared CP0 definitions: exception codes used by CP0 and the exception tracker.
package exc_tracker_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_NONE = 5'h1F;

endpackage

// File: rtl/exc_tracker_slot.sv
// One pipeline slot of the exception tracker: holds on stall, empties on
// flush, and on advance adopts the incoming entry, merging a new exception
// only when the entry is valid and not already faulted (older wins).
module exc_slot
    import exc_tracker_pkg::*;
#(
    parameter int W_ADDR = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [W_ADDR-1:0] in_pc,
    input  logic              in_in_ds,
    input  logic              in_is_exc,
    input  logic              in_is_eret,
    input  logic [4:0]        in_code,
    input  logic [W_ADDR-1:0] in_badvaddr,
    input  logic              set_exc,
    input  logic              set_eret,
    input  logic [4:0]        set_code,
    input  logic              set_bv_en,
    input  logic [W_ADDR-1:0] set_bv,
    output logic              q_valid,
    output logic [W_ADDR-1:0] q_pc,
    output logic              q_in_ds,
    output logic              q_is_exc,
    output logic              q_is_eret,
    output logic [4:0]        q_code,
    output logic [W_ADDR-1:0] q_badvaddr
);

    logic              nx_is_exc;
    logic              nx_is_eret;
    logic [4:0]        nx_code;
    logic [W_ADDR-1:0] nx_badvaddr;

    // Exception fields of the entry being loaded; bubbles never carry a fault
    always_comb begin
        nx_is_exc   = in_is_exc;
        nx_is_eret  = in_is_eret;
        nx_code     = in_code;
        nx_badvaddr = in_badvaddr;
        if (!in_valid) begin
            nx_is_exc  = 1'b0;
            nx_is_eret = 1'b0;
            nx_code    = EXC_NONE;
        end else if (!in_is_exc && set_exc) begin
            nx_is_exc  = 1'b1;
            nx_is_eret = set_eret;
            nx_code    = set_code;
            if (set_bv_en)
                nx_badvaddr = set_bv;
        end
    end

    // Slot register: reset/flush empty it, stall holds, otherwise advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_valid    <= 1'b0;
            q_pc       <= '0;
            q_in_ds    <= 1'b0;
            q_is_exc   <= 1'b0;
            q_is_eret  <= 1'b0;
            q_code     <= EXC_NONE;
            q_badvaddr <= '0;
        end else if (flush) begin
            q_valid    <= 1'b0;
            q_pc       <= '0;
            q_in_ds    <= 1'b0;
            q_is_exc   <= 1'b0;
            q_is_eret  <= 1'b0;
            q_code     <= EXC_NONE;
            q_badvaddr <= '0;
        end else if (!stall) begin
            q_valid    <= in_valid;
            q_pc       <= in_pc;
            q_in_ds    <= in_in_ds;
            q_is_exc   <= nx_is_exc;
            q_is_eret  <= nx_is_eret;
            q_code     <= nx_code;
            q_badvaddr <= nx_badvaddr;
        end
    end

endmodule

// File: rtl/exc_tracker.sv
// Exception tracker: carries each instruction's first exception from ID
// through slots E, M and W so CP0 sees a precise, in-order exception at W.
module exc_tracker
    import exc_tracker_pkg::*;
#(
    parameter int W_ADDR = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [W_ADDR-1:0] id_pc,
    input  logic              id_in_ds,
    input  logic              id_ri,
    input  logic              id_sys,
    input  logic              id_bp,
    input  logic              id_eret,
    input  logic              ex_ov,
    input  logic              mem_adel,
    input  logic              mem_ades,
    input  logic [W_ADDR-1:0] mem_addr,
    output logic              wb_valid,
    output logic [W_ADDR-1:0] wb_pc,
    output logic [W_ADDR-1:0] wb_badvaddr,
    output logic [4:0]        wb_excCode,
    output logic              wb_is_exc,
    output logic              wb_is_in_ds,
    output logic              wb_is_eret,
    output logic              mem_kill
);

    logic              e_valid, e_in_ds, e_is_exc, e_is_eret;
    logic [W_ADDR-1:0] e_pc, e_badvaddr;
    logic [4:0]        e_code;
    logic              m_valid, m_in_ds, m_is_exc, m_is_eret;
    logic [W_ADDR-1:0] m_pc, m_badvaddr;
    logic [4:0]        m_code;

    logic              id_exc, id_exc_eret, id_bv_en;
    logic [4:0]        id_code;
    logic              mem_exc;
    logic [4:0]        mem_code;

    // Decode-stage exception priority: fetch misalignment beats RI, Sys, Bp, eret
    always_comb begin
        id_exc      = 1'b1;
        id_exc_eret = 1'b0;
        id_bv_en    = 1'b0;
        id_code     = EXC_NONE;
        if (id_pc[1:0] != 2'b00) begin
            id_code  = EXC_ADEL;
            id_bv_en = 1'b1;
        end else if (id_ri) begin
            id_code = EXC_RI;
        end else if (id_sys) begin
            id_code = EXC_SYS;
        end else if (id_bp) begin
            id_code = EXC_BP;
        end else if (id_eret) begin
            id_exc_eret = 1'b1;
        end else begin
            id_exc = 1'b0;
        end
    end

    // Data address error for slot M; load error takes precedence over store
    always_comb begin
        mem_exc  = mem_adel | mem_ades;
        mem_code = mem_adel ? EXC_ADEL : EXC_ADES;
    end

    exc_slot #(.W_ADDR(W_ADDR)) u_slot_e (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(id_valid), .in_pc(id_pc), .in_in_ds(id_in_ds),
        .in_is_exc(1'b0), .in_is_eret(1'b0), .in_code(EXC_NONE),
        .in_badvaddr('0),
        .set_exc(id_exc), .set_eret(id_exc_eret), .set_code(id_code),
        .set_bv_en(id_bv_en), .set_bv(id_pc),
        .q_valid(e_valid), .q_pc(e_pc), .q_in_ds(e_in_ds),
        .q_is_exc(e_is_exc), .q_is_eret(e_is_eret), .q_code(e_code),
        .q_badvaddr(e_badvaddr)
    );

    exc_slot #(.W_ADDR(W_ADDR)) u_slot_m (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(e_valid), .in_pc(e_pc), .in_in_ds(e_in_ds),
        .in_is_exc(e_is_exc), .in_is_eret(e_is_eret), .in_code(e_code),
        .in_badvaddr(e_badvaddr),
        .set_exc(ex_ov), .set_eret(1'b0), .set_code(EXC_OV),
        .set_bv_en(1'b0), .set_bv('0),
        .q_valid(m_valid), .q_pc(m_pc), .q_in_ds(m_in_ds),
        .q_is_exc(m_is_exc), .q_is_eret(m_is_eret), .q_code(m_code),
        .q_badvaddr(m_badvaddr)
    );

    exc_slot #(.W_ADDR(W_ADDR)) u_slot_w (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(m_valid), .in_pc(m_pc), .in_in_ds(m_in_ds),
        .in_is_exc(m_is_exc), .in_is_eret(m_is_eret), .in_code(m_code),
        .in_badvaddr(m_badvaddr),
        .set_exc(mem_exc), .set_eret(1'b0), .set_code(mem_code),
        .set_bv_en(1'b1), .set_bv(mem_addr),
        .q_valid(wb_valid), .q_pc(wb_pc), .q_in_ds(wb_is_in_ds),
        .q_is_exc(wb_is_exc), .q_is_eret(wb_is_eret), .q_code(wb_excCode),
        .q_badvaddr(wb_badvaddr)
    );

    // Block the data write of a faulting (or already faulted) instruction in M
    always_comb begin
        mem_kill = m_valid & (m_is_exc | mem_adel | mem_ades);
    end

endmodule

// File: tb/tb_exc_tracker.sv
// Self-checking bench for exc_tracker: directed scenarios plus random traffic
// checked against an instruction-level reference pipeline.
module tb_exc_tracker;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        id_valid, id_in_ds, id_ri, id_sys, id_bp, id_eret;
    logic [31:0] id_pc;
    logic        ex_ov, mem_adel, mem_ades;
    logic [31:0] mem_addr;
    logic        wb_valid, wb_is_exc, wb_is_in_ds, wb_is_eret, mem_kill;
    logic [31:0] wb_pc, wb_badvaddr;
    logic [4:0]  wb_excCode;

    int tests_run    = 0;
    int tests_failed = 0;

    exc_tracker #(.W_ADDR(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_in_ds(id_in_ds),
        .id_ri(id_ri), .id_sys(id_sys), .id_bp(id_bp), .id_eret(id_eret),
        .ex_ov(ex_ov), .mem_adel(mem_adel), .mem_ades(mem_ades),
        .mem_addr(mem_addr),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr),
        .wb_excCode(wb_excCode), .wb_is_exc(wb_is_exc),
        .wb_is_in_ds(wb_is_in_ds), .wb_is_eret(wb_is_eret),
        .mem_kill(mem_kill)
    );

    always #5 clk = ~clk;

    // Reference: one record per in-flight instruction, index 0=E, 1=M, 2=W
    typedef struct {
        bit          v;
        logic [31:0] pc;
        bit          ds;
        bit          exc;
        bit          eret;
        logic [4:0]  code;
        logic [31:0] bv;
    } rec_t;

    rec_t mdl [3];

    function automatic rec_t empty_rec();
        rec_t r;
        r.v = 0; r.pc = 0; r.ds = 0; r.exc = 0; r.eret = 0;
        r.code = 5'd31; r.bv = 0;
        return r;
    endfunction

    // First exception detected at decode, in architectural priority order
    function automatic rec_t decode_rec();
        rec_t r = empty_rec();
        if (!id_valid) return r;
        r.v = 1; r.pc = id_pc; r.ds = id_in_ds;
        if (id_pc % 4 != 0) begin r.exc = 1; r.code = 5'd4; r.bv = id_pc; end
        else if (id_ri)     begin r.exc = 1; r.code = 5'd10; end
        else if (id_sys)    begin r.exc = 1; r.code = 5'd8; end
        else if (id_bp)     begin r.exc = 1; r.code = 5'd9; end
        else if (id_eret)   begin r.exc = 1; r.eret = 1; end
        return r;
    endfunction

    task automatic model_edge();
        rec_t w, m;
        if (reset) begin
            for (int i = 0; i < 3; i++) mdl[i] = empty_rec();
        end else if (flush) begin
            for (int i = 0; i < 3; i++) mdl[i] = empty_rec();
        end else if (!stall) begin
            w = mdl[1];
            if (w.v && !w.exc && (mem_adel || mem_ades)) begin
                w.exc = 1; w.code = mem_adel ? 5'd4 : 5'd5; w.bv = mem_addr;
            end
            m = mdl[0];
            if (m.v && !m.exc && ex_ov) begin m.exc = 1; m.code = 5'd12; end
            mdl[2] = w;
            mdl[1] = m;
            mdl[0] = decode_rec();
        end
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; id_valid = 0; id_pc = 0; id_in_ds = 0;
        id_ri = 0; id_sys = 0; id_bp = 0; id_eret = 0;
        ex_ov = 0; mem_adel = 0; mem_ades = 0; mem_addr = 0;
    endtask

    // Advance one clock and the reference; returns 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1; clear_inputs();
        tick(); tick();
        tests_run++;
        if (wb_valid !== 1'b0 || wb_is_exc !== 1'b0 || wb_excCode !== 5'h1F ||
            mem_kill !== 1'b0 || wb_pc !== 32'h0 || wb_badvaddr !== 32'h0 ||
            wb_is_eret !== 1'b0 || wb_is_in_ds !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b exc=%b code=%h kill=%b pc=%h bv=%h eret=%b ds=%b, want 0 0 1f 0 0 0 0 0",
                     wb_valid, wb_is_exc, wb_excCode, mem_kill, wb_pc, wb_badvaddr, wb_is_eret, wb_is_in_ds);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_ri_drain();
        clear_inputs();
        id_valid = 1; id_pc = 32'hBFC00010; id_ri = 1;
        tick(); clear_inputs(); tick(); tick();
        tests_run++;
        if (wb_valid !== 1'b1 || wb_is_exc !== 1'b1 || wb_excCode !== 5'd10 || wb_pc !== 32'hBFC00010) begin
            tests_failed++;
            $display("FAIL ri_drain: got v=%b exc=%b code=%0d pc=%h, want 1 1 10 bfc00010",
                     wb_valid, wb_is_exc, wb_excCode, wb_pc);
        end
        // Misaligned fetch beats RI and records the PC as badvaddr
        id_valid = 1; id_pc = 32'hBFC00012; id_ri = 1;
        tick(); clear_inputs(); tick(); tick();
        tests_run++;
        if (wb_excCode !== 5'd4 || wb_badvaddr !== 32'hBFC00012 || wb_is_exc !== 1'b1) begin
            tests_failed++;
            $display("FAIL adel_over_ri: got code=%0d bv=%h exc=%b, want 4 bfc00012 1",
                     wb_excCode, wb_badvaddr, wb_is_exc);
        end
    endtask

    task automatic test_older_wins();
        clear_inputs();
        id_valid = 1; id_pc = 32'h00400020; id_ri = 1;
        tick(); clear_inputs();
        ex_ov = 1;
        tick(); clear_inputs();
        mem_ades = 1; mem_addr = 32'h12345677;
        #1;
        tests_run++;
        if (mem_kill !== 1'b1) begin
            tests_failed++;
            $display("FAIL older_wins_kill: got %b want 1", mem_kill);
        end
        tick(); clear_inputs();
        tests_run++;
        if (wb_excCode !== 5'd10 || wb_badvaddr !== 32'h0 || wb_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL older_wins: got code=%0d bv=%h v=%b, want 10 0 1",
                     wb_excCode, wb_badvaddr, wb_valid);
        end
    endtask

    task automatic test_store_error();
        clear_inputs();
        id_valid = 1; id_pc = 32'h80001000;
        tick(); clear_inputs(); tick();
        #1;
        tests_run++;
        if (mem_kill !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_no_kill: got %b want 0", mem_kill);
        end
        mem_ades = 1; mem_addr = 32'h80000003;
        #1;
        tests_run++;
        if (mem_kill !== 1'b1) begin
            tests_failed++;
            $display("FAIL store_kill: got %b want 1", mem_kill);
        end
        tick(); clear_inputs();
        tests_run++;
        if (wb_excCode !== 5'd5 || wb_badvaddr !== 32'h80000003 || wb_is_exc !== 1'b1) begin
            tests_failed++;
            $display("FAIL store_error: got code=%0d bv=%h exc=%b, want 5 80000003 1",
                     wb_excCode, wb_badvaddr, wb_is_exc);
        end
        // Both load and store errors: load error code wins
        id_valid = 1; id_pc = 32'h80002000;
        tick(); clear_inputs(); tick();
        mem_adel = 1; mem_ades = 1; mem_addr = 32'h80000101;
        tick(); clear_inputs();
        tests_run++;
        if (wb_excCode !== 5'd4 || wb_badvaddr !== 32'h80000101) begin
            tests_failed++;
            $display("FAIL adel_over_ades: got code=%0d bv=%h, want 4 80000101",
                     wb_excCode, wb_badvaddr);
        end
    endtask

    task automatic test_flush_over_stall();
        clear_inputs();
        id_valid = 1; id_pc = 32'h100; tick();
        id_pc = 32'h104; tick();
        id_pc = 32'h108; tick();
        clear_inputs();
        stall = 1; flush = 1;
        tick(); clear_inputs();
        mem_adel = 1;
        #1;
        tests_run++;
        if (wb_valid !== 1'b0 || mem_kill !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_over_stall: got v=%b kill=%b, want 0 0", wb_valid, mem_kill);
        end
        clear_inputs();
        tick(); tick();
        tests_run++;
        if (wb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_drain: got v=%b want 0 (E/M not emptied)", wb_valid);
        end
    endtask

    task automatic test_stall_hold();
        clear_inputs();
        id_valid = 1; id_pc = 32'h200; id_sys = 1;
        tick(); clear_inputs(); tick(); tick();
        stall = 1; id_valid = 1; id_pc = 32'h300;
        tick(); tick();
        tests_run++;
        if (wb_valid !== 1'b1 || wb_pc !== 32'h200 || wb_excCode !== 5'd8) begin
            tests_failed++;
            $display("FAIL stall_hold: got v=%b pc=%h code=%0d, want 1 200 8",
                     wb_valid, wb_pc, wb_excCode);
        end
        clear_inputs();
    endtask

    task automatic test_eret_ds();
        clear_inputs();
        id_valid = 1; id_pc = 32'hBFC00380; id_eret = 1; id_in_ds = 1;
        tick(); clear_inputs(); tick(); tick();
        tests_run++;
        if (wb_is_eret !== 1'b1 || wb_is_exc !== 1'b1 || wb_excCode !== 5'h1F || wb_is_in_ds !== 1'b1) begin
            tests_failed++;
            $display("FAIL eret_ds: got eret=%b exc=%b code=%h ds=%b, want 1 1 1f 1",
                     wb_is_eret, wb_is_exc, wb_excCode, wb_is_in_ds);
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        id_valid = 1; id_pc = 32'h401; tick();
        id_pc = 32'h404; id_bp = 1; tick();
        id_pc = 32'h408; id_bp = 0; id_ri = 1; tick();
        clear_inputs();
        #2;
        reset = 1;
        #1;
        tests_run++;
        if (wb_valid !== 1'b0 || wb_is_exc !== 1'b0 || wb_excCode !== 5'h1F ||
            wb_pc !== 32'h0 || wb_badvaddr !== 32'h0 || mem_kill !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got v=%b exc=%b code=%h pc=%h bv=%h kill=%b, want 0 0 1f 0 0 0",
                     wb_valid, wb_is_exc, wb_excCode, wb_pc, wb_badvaddr, mem_kill);
        end
        tick();
        reset = 0;
        tick(); tick(); tick();
        tests_run++;
        if (wb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset_no_retire: got v=%b want 0", wb_valid);
        end
    endtask

    task automatic test_random();
        bit exp_kill;
        for (int i = 0; i < 400; i++) begin
            stall    = ($urandom_range(0, 99) < 20);
            flush    = ($urandom_range(0, 99) < 5);
            id_valid = ($urandom_range(0, 99) < 75);
            id_pc    = $urandom & 32'hFFFFFFFC;
            if ($urandom_range(0, 99) < 10) id_pc[1:0] = 2'($urandom_range(1, 3));
            id_in_ds = $urandom_range(0, 1);
            id_ri    = ($urandom_range(0, 99) < 10);
            id_sys   = ($urandom_range(0, 99) < 10);
            id_bp    = ($urandom_range(0, 99) < 10);
            id_eret  = ($urandom_range(0, 99) < 10);
            ex_ov    = ($urandom_range(0, 99) < 15);
            mem_adel = ($urandom_range(0, 99) < 10);
            mem_ades = ($urandom_range(0, 99) < 10);
            mem_addr = $urandom;
            #1;
            exp_kill = mdl[1].v && (mdl[1].exc || mem_adel || mem_ades);
            tests_run++;
            if (mem_kill !== exp_kill) begin
                tests_failed++;
                $display("FAIL rand_kill[%0d]: got %b want %b", i, mem_kill, exp_kill);
            end
            tick();
            tests_run++;
            if (wb_valid !== mdl[2].v ||
                (mdl[2].v && (wb_pc !== mdl[2].pc || wb_is_in_ds !== mdl[2].ds ||
                              wb_is_exc !== mdl[2].exc || wb_is_eret !== mdl[2].eret ||
                              wb_excCode !== mdl[2].code ||
                              (mdl[2].exc && wb_badvaddr !== mdl[2].bv)))) begin
                tests_failed++;
                $display("FAIL rand_wb[%0d]: got v=%b pc=%h ds=%b exc=%b eret=%b code=%0d bv=%h, want v=%b pc=%h ds=%b exc=%b eret=%b code=%0d bv=%h",
                         i, wb_valid, wb_pc, wb_is_in_ds, wb_is_exc, wb_is_eret, wb_excCode, wb_badvaddr,
                         mdl[2].v, mdl[2].pc, mdl[2].ds, mdl[2].exc, mdl[2].eret, mdl[2].code, mdl[2].bv);
            end
        end
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) mdl[i] = empty_rec();
        test_reset();
        test_ri_drain();
        test_older_wins();
        test_store_error();
        test_flush_over_stall();
        test_stall_hold();
        test_eret_ds();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
